mean_square_acc: RTL and testbench

Streaming mean-square accumulator sitting directly upstream of the combinational square-root stage in the RMS path. Accepts a stream of signed samples over a valid/ready handshake, accumulates the squares of 2^LOG2N consecutive samples, divides by the window length and presents the unsigned mean square as the radicand for the `sqrt` block. Its output register holds the radicand stable for as long as the downstream side needs it.

---
 rtl/mean_square_acc.sv | 98 +++++++++
 tb/tb_mean_square_acc.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mean_square_acc.sv
// Streaming mean-square accumulator: averages the squares of 2^LOG2N samples.
// Optional MEAN_SQ_ROUND_EN selects round-half-up division instead of truncation.
module mean_square_acc #(
  parameter int DATA_W = 8,
  parameter int LOG2N  = 4,
  parameter int OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int SQ_W  = 2 * DATA_W;
  localparam int ACC_W = SQ_W + LOG2N;
  localparam int RES_W = ACC_W + 1 - LOG2N;
  localparam int CMP_W = (RES_W > OUT_W) ? RES_W : OUT_W;

`ifdef MEAN_SQ_ROUND_EN
  localparam logic [ACC_W:0] ROUND_ADD = (ACC_W + 1)'(1) << (LOG2N - 1);
`else
  localparam logic [ACC_W:0] ROUND_ADD = '0;
`endif

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg;
  logic [LOG2N-1:0]   count_reg;
  logic [OUT_W-1:0]   out_data_reg;

  logic signed [SQ_W-1:0] data_ext;
  logic signed [SQ_W-1:0] product;
  logic [SQ_W-1:0]        square;
  logic [ACC_W:0]         window_sum;
  logic [RES_W-1:0]       result;
  logic [CMP_W-1:0]       result_ext;
  logic [CMP_W-1:0]       max_ext;
  logic [OUT_W-1:0]       result_sat;
  logic                   accept;
  logic                   last_sample;

  // The true square never exceeds 2^(2*DATA_W-2), so the truncated product is exact.
  assign data_ext = {{DATA_W{in_data[DATA_W-1]}}, in_data};
  assign product  = data_ext * data_ext;
  assign square   = $unsigned(product);

  assign window_sum = {1'b0, acc_reg} + (ACC_W + 1)'(square) + ROUND_ADD;
  assign result     = window_sum[ACC_W:LOG2N];
  assign result_ext = CMP_W'(result);
  assign max_ext    = CMP_W'({OUT_W{1'b1}});
  assign result_sat = (result_ext > max_ext) ? {OUT_W{1'b1}} : result_ext[OUT_W-1:0];

  assign in_ready    = (state_reg == ACCUM);
  assign out_valid   = (state_reg == HOLD);
  assign out_data    = out_data_reg;
  assign accept      = in_valid & in_ready;
  assign last_sample = (count_reg == {LOG2N{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM: if (accept && last_sample) state_next = HOLD;
      HOLD:  if (out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg      <= '0;
      count_reg    <= '0;
      out_data_reg <= '0;
    end else if (accept) begin
      if (last_sample) begin
        out_data_reg <= result_sat;
        acc_reg      <= '0;
        count_reg    <= '0;
      end else begin
        acc_reg   <= acc_reg + ACC_W'(square);
        count_reg <= count_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mean_square_acc.sv
// Directed self-checking bench for mean_square_acc (default parameters).
module tb_mean_square_acc;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       out_data;
  logic              out_valid;
  logic              out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string             name;
    int                n1;
    logic signed [7:0] a;
    int                n2;
    logic signed [7:0] b;
    logic [15:0]       expv;
  } win_t;

  win_t tbl[4];

  mean_square_acc #(.DATA_W(8), .LOG2N(4), .OUT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams n1 copies of a then n2 copies of b with no bubbles, out_ready high.
  task automatic run_window(input string name, input int n1, input logic signed [7:0] a,
                            input int n2, input logic signed [7:0] b, input logic [15:0] expv);
    out_ready = 1'b1;
    for (int i = 0; i < n1 + n2; i++) begin
      in_valid = 1'b1;
      in_data  = (i < n1) ? a : b;
      tick();
      if (i < n1 + n2 - 1) check({name, "_early_valid"}, 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"}, 32'(out_data), 32'(expv));
    check({name, "_in_ready_hold"}, 32'(in_ready), 32'd0);
    $display("window %s: out_data=%0d expected=%0d", name, out_data, expv);
    tick();
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int accepts;
    int cycles;
    logic accepted;

    tbl[0] = '{"threes", 16, 8'sd3, 0, 8'sd0, 16'd9};
    tbl[1] = '{"neg128", 16, -8'sd128, 0, 8'sd0, 16'd16384};
    tbl[2] = '{"pos127", 16, 8'sd127, 0, 8'sd0, 16'd16129};
`ifdef MEAN_SQ_ROUND_EN
    tbl[3] = '{"ones_twos", 8, 8'sd1, 8, 8'sd2, 16'd3};
`else
    tbl[3] = '{"ones_twos", 8, 8'sd1, 8, 8'sd2, 16'd2};
`endif

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    $display("reset: out_valid=%0d in_ready=%0d out_data=%0d", out_valid, in_ready, out_data);

    for (int t = 0; t < 4; t++) begin
      run_window(tbl[t].name, tbl[t].n1, tbl[t].a, tbl[t].n2, tbl[t].b, tbl[t].expv);
    end

    // Hold with out_ready low while upstream keeps offering 100.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'sd5;
      tick();
    end
    in_data = 8'sd100;
    for (int i = 0; i < 6; i++) begin
      check("stall_data", 32'(out_data), 32'd25);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    $display("stall window: out_data=%0d expected=25", out_data);
    out_ready = 1'b1;
    tick();
    check("stall_release_in_ready", 32'(in_ready), 32'd1);
    check("stall_release_valid", 32'(out_valid), 32'd0);
    check("stall_data_kept", 32'(out_data), 32'd25);
    run_window("after_stall", 16, 8'sd2, 0, 8'sd0, 16'd4);

    // Reset mid-window, with an offered sample in the reset cycle.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 8'sd10;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("midreset_out_data", 32'(out_data), 32'd0);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    $display("mid-window reset: out_data=%0d out_valid=%0d", out_data, out_valid);
    run_window("after_reset", 16, 8'sd4, 0, 8'sd0, 16'd16);

    // Random bubbles; invalid cycles carry a poison value.
    accepts = 0; cycles = 0; out_ready = 1'b1;
    while (accepts < 16 && cycles < 400) begin
      accepted = 1'(($urandom_range(0, 1) == 1) || (cycles > 300));
      in_valid = accepted;
      in_data  = accepted ? -8'sd6 : 8'sd77;
      tick();
      cycles++;
      if (accepted) accepts++;
      if (accepts < 16) check("bubble_early_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    if (accepts < 16) begin
      check("bubble_timeout", 32'(accepts), 32'd16);
    end else begin
      check("bubble_valid", 32'(out_valid), 32'd1);
      check("bubble_data", 32'(out_data), 32'd36);
      $display("bubble window: out_data=%0d expected=36 cycles=%0d", out_data, cycles);
      tick();
      check("bubble_valid_drop", 32'(out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
